// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: fetch-stage bundle grouping the memory request/response, decoder and next-PC channels.
interface ifu_fetch_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic            resp_err;
  logic [XLEN-1:0] resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic            inst_fault;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            dnpc_valid;
  logic [XLEN-1:0] dnpc;
  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc, inst_fault,
    input  req_ready, resp_valid, resp_data, resp_err, inst_ready, dnpc_valid, dnpc
  );
  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc, inst_fault,
    output req_ready, resp_valid, resp_data, resp_err, inst_ready, dnpc_valid, dnpc
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle fetch stage, one outstanding read, PC supplied only via dnpc.
// Optional IFU_MISALIGN_CHECK_EN turns a misaligned PC into a faulting instruction without a memory request.
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h80000000
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_WAIT_NPC} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic            inst_fault_q, inst_fault_d, misalign;
`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign = |pc_q[1:0];
`else
  assign misalign = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    case (state_q)
      S_REQ: begin
        if (misalign) begin
          state_d      = S_HOLD;
          inst_d       = '0;
          inst_pc_d    = pc_q;
          inst_fault_d = 1'b1;
        end else if (bus.req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.resp_valid) begin
          state_d      = S_HOLD;
          inst_d       = bus.resp_data;
          inst_pc_d    = pc_q;
          inst_fault_d = bus.resp_err;
        end
      end
      S_HOLD: begin
        if (bus.inst_ready) begin
          state_d = bus.dnpc_valid ? S_REQ : S_WAIT_NPC;
          pc_d    = bus.dnpc_valid ? bus.dnpc : pc_q;
        end
      end
      default: begin
        state_d = bus.dnpc_valid ? S_REQ : S_WAIT_NPC;
        pc_d    = bus.dnpc_valid ? bus.dnpc : pc_q;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end
  // outputs depend only on registered state, never on this cycle's inputs
  assign bus.req_valid  = (state_q == S_REQ) && !misalign;
  assign bus.req_addr   = pc_q;
  assign bus.inst_valid = state_q == S_HOLD;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_fault = inst_fault_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: vector table, hand-written corner sequences and a randomized run against a transaction-level model.
module tb_ifu_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  ifu_fetch_if #(.XLEN(32)) bus ();
  ifu_fetch #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic        rr, rv;
    logic [31:0] rd;
    logic        re, ir, dv;
    logic [31:0] dn;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_ipc;
    logic        e_f;
  } vec_t;
  typedef enum {P_REQ, P_MEM, P_DEC, P_NPC} phase_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic rr, input logic rv, input logic [31:0] rd, input logic re,
                       input logic ir, input logic dv, input logic [31:0] dn);
    bus.req_ready  = rr;
    bus.resp_valid = rv;
    bus.resp_data  = rd;
    bus.resp_err   = re;
    bus.inst_ready = ir;
    bus.dnpc_valid = dv;
    bus.dnpc       = dn;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int reqs;
    phase_t ph;
    logic [31:0] exp_pc, exp_inst, exp_ipc;
    logic exp_f;
    logic rr, rv, re, ir, dv;
    logic [31:0] rd, dn;
    vecs[0]  = '{1, 0, 32'h0, 0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0,        0};
    vecs[1]  = '{1, 1, 32'h00100073, 0, 1, 1, 32'h0BAD0000, 0, 32'h0,   1, 32'h00100073, 32'h80000000, 0};
    vecs[2]  = '{0, 0, 32'h0, 0, 1, 1, 32'h80000004,   1, 32'h80000004, 0, 32'h0,        32'h0,        0};
    vecs[3]  = '{1, 0, 32'h0, 0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0,        0};
    vecs[4]  = '{0, 1, 32'hDEADBEEF, 1, 0, 0, 32'h0,   0, 32'h0,        1, 32'hDEADBEEF, 32'h80000004, 1};
    vecs[5]  = '{0, 0, 32'h0, 0, 1, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0,        0};
    vecs[6]  = '{0, 0, 32'h0, 0, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        32'h0,        0};
    vecs[7]  = '{0, 0, 32'h0, 0, 0, 1, 32'h80000100,   1, 32'h80000100, 0, 32'h0,        32'h0,        0};
    vecs[8]  = '{1, 1, 32'h11111111, 1, 0, 1, 32'hDEAD0000, 0, 32'h0,   0, 32'h0,        32'h0,        0};
    vecs[9]  = '{0, 1, 32'h00000013, 0, 0, 0, 32'h0,   0, 32'h0,        1, 32'h00000013, 32'h80000100, 0};
    vecs[10] = '{0, 1, 32'hFFFFFFFF, 1, 0, 1, 32'h12345678, 0, 32'h0,   1, 32'h00000013, 32'h80000100, 0};
    vecs[11] = '{0, 0, 32'h0, 0, 1, 1, 32'h80000108,   1, 32'h80000108, 0, 32'h0,        32'h0,        0};
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_valid", bus.req_valid, 1);
    chk("rst_req_addr", bus.req_addr, 32'h80000000);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);
    chk("rst_inst_fault", bus.inst_fault, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].re, vecs[i].ir, vecs[i].dv, vecs[i].dn);
      step();
      chk($sformatf("vec%0d_req_valid", i), bus.req_valid, vecs[i].e_rv);
      if (vecs[i].e_rv) chk($sformatf("vec%0d_req_addr", i), bus.req_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_inst_valid", i), bus.inst_valid, vecs[i].e_iv);
      if (vecs[i].e_iv) begin
        chk($sformatf("vec%0d_inst", i), bus.inst, vecs[i].e_inst);
        chk($sformatf("vec%0d_inst_pc", i), bus.inst_pc, vecs[i].e_ipc);
        chk($sformatf("vec%0d_inst_fault", i), bus.inst_fault, vecs[i].e_f);
      end
    end
    reqs = 0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 32'h77777777, 0, 1, 1, 32'h0);
      if (bus.req_valid && bus.req_ready) reqs++;
      step();
      chk("bp_req_valid", bus.req_valid, 1);
      chk("bp_req_addr", bus.req_addr, 32'h80000108);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    if (bus.req_valid && bus.req_ready) reqs++;
    step();
    chk("bp_accept", bus.req_valid, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 1, 1, 32'h0);
      if (bus.req_valid && bus.req_ready) reqs++;
      step();
      chk("bp_wait_req_valid", bus.req_valid, 0);
      chk("bp_wait_inst_valid", bus.inst_valid, 0);
    end
    drive(0, 1, 32'h0000A0B3, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", bus.inst_valid, 1);
      chk("bp_hold_inst", bus.inst, 32'h0000A0B3);
      chk("bp_hold_pc", bus.inst_pc, 32'h80000108);
      drive(1, 1, 32'h99999999, 1, 0, 1, 32'h44444444);
      step();
    end
    chk("bp_hold_last", bus.inst, 32'h0000A0B3);
    drive(0, 0, 0, 0, 1, 1, 32'h80000200);
    step();
    chk("bp_next_req_valid", bus.req_valid, 1);
    chk("bp_next_req_addr", bus.req_addr, 32'h80000200);
    chk("bp_one_request", reqs, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 32'h55555555, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req_valid", bus.req_valid, 1);
    chk("async_rst_req_addr", bus.req_addr, 32'h80000000);
    chk("async_rst_inst_valid", bus.inst_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst2_req_valid", bus.req_valid, 1);
    chk("rst2_req_addr", bus.req_addr, 32'h80000000);
    chk("rst2_inst", bus.inst, 0);
    step();
    chk("stale_resp_req_valid", bus.req_valid, 1);
    chk("stale_resp_inst_valid", bus.inst_valid, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 32'h00000093, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 1, 32'h80000002);
    step();
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_no_req", bus.req_valid, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    chk("mis_inst_valid", bus.inst_valid, 1);
    chk("mis_inst", bus.inst, 0);
    chk("mis_inst_pc", bus.inst_pc, 32'h80000002);
    chk("mis_fault", bus.inst_fault, 1);
`else
    chk("mis_req_valid", bus.req_valid, 1);
    chk("mis_req_addr", bus.req_addr, 32'h80000002);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 32'h00000013, 0, 0, 0, 0);
    step();
    chk("mis_off_inst_pc", bus.inst_pc, 32'h80000002);
`endif
    drive(0, 0, 0, 0, 1, 1, 32'h80000000);
    step();
    chk("mis_resume_addr", bus.req_addr, 32'h80000000);
    ph = P_REQ;
    exp_pc = 32'h80000000;
    exp_inst = 0;
    exp_ipc = 0;
    exp_f = 0;
    for (int n = 0; n < 1500; n++) begin
      chk("rnd_req_valid", bus.req_valid, ph == P_REQ);
      if (ph == P_REQ) chk("rnd_req_addr", bus.req_addr, exp_pc);
      chk("rnd_inst_valid", bus.inst_valid, ph == P_DEC);
      if (ph == P_DEC) begin
        chk("rnd_inst", bus.inst, exp_inst);
        chk("rnd_inst_pc", bus.inst_pc, exp_ipc);
        chk("rnd_inst_fault", bus.inst_fault, exp_f);
      end
      rr = 1'($urandom_range(0, 1));
      rv = (ph == P_MEM) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
      rd = $urandom;
      re = $urandom_range(0, 7) == 0;
      ir = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      dn = $urandom & 32'hFFFFFFFC;
      drive(rr, rv, rd, re, ir, dv, dn);
      step();
      case (ph)
        P_REQ: if (rr) ph = P_MEM;
        P_MEM: if (rv) begin
          exp_inst = rd;
          exp_ipc = exp_pc;
          exp_f = re;
          ph = P_DEC;
        end
        P_DEC: if (ir) begin
          ph = dv ? P_REQ : P_NPC;
          if (dv) exp_pc = dn;
        end
        default: if (dv) begin
          ph = P_REQ;
          exp_pc = dn;
        end
      endcase
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
